fp16_dot_sequencer: RTL and testbench

//  Sequences shared combinational FP16 multiplier and FP16adder units to compute a dot product,
//  sum(a[i]*b[i]) for i=0..len-1, streamed in as operand pairs.

---
 rtl/fp16_dot_sequencer.sv | 127 ++++++++++++
 tb/tb_fp16_dot_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_dot_sequencer.sv
// FP16 dot-product sequencer: drives external combinational multiplier/adder units, owns acc/count/FSM.
// Optional FP16_ZERO_SKIP_EN: pairs with a +/-0 operand bypass the multiply/accumulate steps.
module fp16_dot_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_p,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    MUL  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state, state_next;
  logic [15:0]      op_a, op_a_next;
  logic [15:0]      op_b, op_b_next;
  logic [15:0]      prod, prod_next;
  logic [15:0]      acc, acc_next;
  logic [LEN_W-1:0] count, count_next;
  logic             zero_pair;

`ifdef FP16_ZERO_SKIP_EN
  assign zero_pair = (in_a[14:0] == 15'h0000) || (in_b[14:0] == 15'h0000);
`else
  assign zero_pair = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= 16'h0000;
      op_b  <= 16'h0000;
      prod  <= 16'h0000;
      acc   <= 16'h0000;
      count <= '0;
    end else begin
      state <= state_next;
      op_a  <= op_a_next;
      op_b  <= op_b_next;
      prod  <= prod_next;
      acc   <= acc_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    op_a_next  = op_a;
    op_b_next  = op_b;
    prod_next  = prod;
    acc_next   = acc;
    count_next = count;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next = 16'h0000;
          if (len != '0) begin
            count_next = len;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          op_a_next = in_a;
          op_b_next = in_b;
          if (zero_pair) begin
            // skipped pair still consumes one element of the vector
            count_next = count - ONE;
            state_next = (count == ONE) ? DONE : RUN;
          end else begin
            state_next = MUL;
          end
        end
      end
      MUL: begin
        prod_next  = mul_p;
        state_next = ACC;
      end
      ACC: begin
        acc_next   = add_sum;
        count_next = count - ONE;
        state_next = (count == ONE) ? DONE : RUN;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign add_a     = acc;
  assign add_b     = prod;
  assign out_data  = acc;

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Self-checking bench for fp16_dot_sequencer; stand-in FP16 units built on real arithmetic.
module tb_fp16_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic [15:0] mul_a, mul_b, mul_p;
  logic [15:0] add_a, add_b, add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int total = 0;
  int bad = 0;

`ifdef FP16_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic [15:0] pa [256];
  logic [15:0] pb [256];
  logic [15:0] vals [11] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h4000, 16'hC000,
                             16'h3800, 16'hB800, 16'h4200, 16'h4400, 16'hC400};

  fp16_dot_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // FP16 <-> real for normal numbers and zero (stimulus keeps every value exact)
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    m = 1.0 + real'({22'd0, h[9:0]}) / 1024.0;
    e = int'({27'd0, h[14:10]}) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real a;
    int  e;
    int  m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    return {s, e[4:0], m[9:0]};
  endfunction

  assign mul_p   = r2h(h2r(mul_a) * h2r(mul_b));
  assign add_sum = r2h(h2r(add_a) + h2r(add_b));

  task automatic run_dot(input int L, input bit gaps, input bit noisy, input int hold, input string name);
    real         s;
    int          exp_lat;
    int          idx;
    int          cyc;
    bit          take;
    bit          saw_ready;
    logic [15:0] exp_data;
    s = 0.0;
    exp_lat = 1;
    for (int i = 0; i < L; i++) begin
      s = s + h2r(pa[i]) * h2r(pb[i]);
      exp_lat += (ZSKIP && (pa[i][14:0] == 15'h0 || pb[i][14:0] == 15'h0)) ? 1 : 3;
    end
    exp_data = r2h(s);
    start = 1'b1; len = L[7:0]; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; idx = 0; saw_ready = 1'b0;
    while (!out_valid && cyc < 400) begin
      in_valid = (idx < L) && (!gaps || $urandom_range(0, 2) != 0);
      if (idx < L) begin in_a = pa[idx]; in_b = pb[idx]; end
      start = noisy && ($urandom_range(0, 1) == 1);
      len = 8'($urandom);
      if (in_ready) saw_ready = 1'b1;
      take = in_ready && in_valid;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cyc);
    end
    total++;
    if (out_data !== exp_data) begin
      bad++; $display("FAIL %s data: got %h required %h", name, out_data, exp_data);
    end
    if (!gaps) begin
      total++;
      if (cyc !== exp_lat) begin
        bad++; $display("FAIL %s latency: got %0d required %0d", name, cyc, exp_lat);
      end
    end
    if (L == 0) begin
      total++;
      if (saw_ready !== 1'b0) begin
        bad++; $display("FAIL %s in_ready: got %b required 0", name, saw_ready);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_data) begin
        bad++; $display("FAIL %s hold: valid=%b data=%h required 1/%h", name, out_valid, out_data, exp_data);
      end
    end
    // start coinciding with the result handshake must be dropped
    out_ready = 1'b1; start = 1'b1; len = 8'd1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL %s to_idle: busy=%b valid=%b required 0/0", name, busy, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s start_ignored: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({in_ready, out_valid, busy, mul_a, mul_b, add_a, add_b, out_data} !== 83'd0) begin
      bad++; $display("FAIL reset_init: ready=%b valid=%b busy=%b data=%h required all 0",
                      in_ready, out_valid, busy, out_data);
    end
    rst = 1'b0;
    pa[0] = 16'h4200; pb[0] = 16'h4000;
    start = 1'b1; len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, busy, mul_a, mul_b, add_a, add_b, out_data} !== 83'd0) begin
      bad++; $display("FAIL reset_async: busy=%b mul_a=%h add_a=%h add_b=%h required all 0",
                      busy, mul_a, add_a, add_b);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_len2;
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    pa[1] = 16'h3800; pb[1] = 16'h4400;
    run_dot(2, 1'b0, 1'b0, 0, "len2");
  endtask

  task automatic test_len0;
    run_dot(0, 1'b0, 1'b0, 0, "len0");
  endtask

  task automatic test_hold;
    pa[0] = 16'h4200; pb[0] = 16'h4000;
    run_dot(1, 1'b0, 1'b0, 5, "hold");
  endtask

  task automatic test_reset_mul;
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    in_a = 16'h4000; in_b = 16'h4000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_a = 16'h4200; in_b = 16'h4200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || mul_a !== 16'h4200 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mul_pre: busy=%b mul_a=%h ready=%b required 1/4200/0", busy, mul_a, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || add_a !== 16'h0000 || out_data !== 16'h0000) begin
      bad++; $display("FAIL rst_mul: busy=%b acc=%h required 0/0000", busy, add_a);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    pa[0] = 16'h3C00; pb[0] = 16'h3C00;
    run_dot(1, 1'b0, 1'b0, 0, "after_rst");
  endtask

  task automatic test_zero_skip;
    pa[0] = 16'h0000; pb[0] = 16'h4000;
    pa[1] = 16'h3C00; pb[1] = 16'h4000;
    run_dot(2, 1'b0, 1'b0, 0, "zero_skip");
    pa[0] = 16'h3C00; pb[0] = 16'h8000;
    pa[1] = 16'h8000; pb[1] = 16'h0000;
    pa[2] = 16'h4200; pb[2] = 16'hC000;
    run_dot(3, 1'b0, 1'b0, 1, "zero_mix");
  endtask

  task automatic test_random;
    int L;
    for (int t = 0; t < 12; t++) begin
      L = $urandom_range(1, 12);
      for (int i = 0; i < L; i++) begin
        pa[i] = vals[$urandom_range(0, 10)];
        pb[i] = vals[$urandom_range(0, 10)];
      end
      run_dot(L, t[0], t[1], $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) begin
        pa[i] = vals[$urandom_range(2, 10)];
        pb[i] = vals[$urandom_range(0, 10)];
      end
      run_dot(8, 1'b0, 1'b0, 0, "b2b");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_a = 16'h0000; in_b = 16'h0000; out_ready = 1'b0;
    #12;
    test_reset;
    test_len2;
    test_len0;
    test_hold;
    test_reset_mul;
    test_zero_skip;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
